// File: rtl/seg7_sequence_monitor.sv
// Seven-segment receive monitor: synchronises the segment bus, waits for a
// pattern to stay stable, decodes it to a digit and checks that accepted
// digits count up by one, wrapping after SEQ_MAX.
//
// state | meaning
// ------+-----------------------------------------------
// WAIT  | candidate pattern seen, counting stable clocks
// LOCK  | candidate accepted, idle until the bus changes
module seg7_sequence_monitor #(
   parameter int STABLE_CYCLES = 16,
   parameter int SEQ_MAX       = 7
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_ena,
   input  logic [6:0] i_seg_in,
   input  logic       i_clear_err,
   output logic [3:0] o_digit,
   output logic       o_digit_valid,
   output logic       o_blank,
   output logic       o_invalid,
   output logic       o_seq_err,
   output logic [7:0] o_change_count
);

   typedef enum logic {WAIT, LOCK} state_t;

   localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);
   localparam logic [3:0] SEQ_LAST  = 4'(SEQ_MAX);

   logic [6:0] r_sync1;
   logic [6:0] r_sync2;
   logic [6:0] r_cand;
   logic [7:0] r_stab_cnt;
   state_t     r_state;
   logic [6:0] r_last_pattern;
   logic       r_acc_valid;
   logic       r_have_prev;
   logic [3:0] r_prev;
   logic [3:0] r_digit;
   logic       r_digit_valid;
   logic       r_blank;
   logic       r_invalid;
   logic       r_seq_err;
   logic [7:0] r_change_count;

   logic [3:0] w_dec_digit;
   logic       w_dec_legal;
   logic       w_dec_blank;
   logic [3:0] w_expected;

   // Decode the candidate pattern {g,f,e,d,c,b,a} into a digit or blank.
   always_comb begin
      w_dec_digit = 4'd0;
      w_dec_legal = 1'b1;
      w_dec_blank = 1'b0;
      case (r_cand)
         7'b0111111: w_dec_digit = 4'd0;
         7'b0000110: w_dec_digit = 4'd1;
         7'b1011011: w_dec_digit = 4'd2;
         7'b1001111: w_dec_digit = 4'd3;
         7'b1100110: w_dec_digit = 4'd4;
         7'b1101101: w_dec_digit = 4'd5;
         7'b1111101: w_dec_digit = 4'd6;
         7'b0000111: w_dec_digit = 4'd7;
         7'b1111111: w_dec_digit = 4'd8;
         7'b1101111: w_dec_digit = 4'd9;
         7'b0000000: begin
            w_dec_legal = 1'b0;
            w_dec_blank = 1'b1;
         end
         default:    w_dec_legal = 1'b0;
      endcase
   end

   // Digit that must follow the previously accepted one.
   always_comb begin
      w_expected = (r_prev == SEQ_LAST) ? 4'd0 : r_prev + 4'd1;
   end

   // Synchroniser, stability FSM, acceptance and sequence checking.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_sync1        <= '0;
         r_sync2        <= '0;
         r_cand         <= '0;
         r_stab_cnt     <= '0;
         r_state        <= WAIT;
         r_last_pattern <= '0;
         r_acc_valid    <= 1'b0;
         r_have_prev    <= 1'b0;
         r_prev         <= '0;
         r_digit        <= '0;
         r_digit_valid  <= 1'b0;
         r_blank        <= 1'b0;
         r_invalid      <= 1'b0;
         r_seq_err      <= 1'b0;
         r_change_count <= '0;
      end else begin
         r_sync1       <= i_seg_in;
         r_sync2       <= r_sync1;
         r_digit_valid <= 1'b0;
         // Clear first so a same-edge error set below takes priority.
         if (i_clear_err) r_seq_err <= 1'b0;
         if (i_ena) begin
            if (r_sync2 != r_cand) begin
               r_cand     <= r_sync2;
               r_stab_cnt <= '0;
               r_state    <= WAIT;
            end else if (r_state == WAIT) begin
               if (r_stab_cnt != STAB_LAST) begin
                  r_stab_cnt <= r_stab_cnt + 8'd1;
               end else begin
                  r_state <= LOCK;
                  // A glitch that settles back on the old pattern is ignored.
                  if (!(r_acc_valid && (r_cand == r_last_pattern))) begin
                     r_last_pattern <= r_cand;
                     r_acc_valid    <= 1'b1;
                     if (w_dec_legal) begin
                        r_digit        <= w_dec_digit;
                        r_digit_valid  <= 1'b1;
                        r_blank        <= 1'b0;
                        r_invalid      <= 1'b0;
                        r_change_count <= r_change_count + 8'd1;
                        if (r_have_prev && (w_dec_digit != w_expected))
                           r_seq_err <= 1'b1;
                        r_prev      <= w_dec_digit;
                        r_have_prev <= 1'b1;
                     end else begin
                        r_blank     <= w_dec_blank;
                        r_invalid   <= ~w_dec_blank;
                        r_have_prev <= 1'b0;
                     end
                  end
               end
            end
         end
      end
   end

   assign o_digit        = r_digit;
   assign o_digit_valid  = r_digit_valid;
   assign o_blank        = r_blank;
   assign o_invalid      = r_invalid;
   assign o_seq_err      = r_seq_err;
   assign o_change_count = r_change_count;

endmodule

// File: tb/tb_seg7_sequence_monitor.sv
// Directed bench for seg7_sequence_monitor (default parameters).
module tb_seg7_sequence_monitor;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [6:0] seg_in;
   logic       clear_err;
   logic [3:0] digit;
   logic       digit_valid;
   logic       blank;
   logic       invalid;
   logic       seq_err;
   logic [7:0] change_count;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;
   logic [3:0] pulse_digit = '0;
   logic prev_dv = 1'b0;
   logic [6:0] seg_tab [10];

   seg7_sequence_monitor dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_ena          (ena),
      .i_seg_in       (seg_in),
      .i_clear_err    (clear_err),
      .o_digit        (digit),
      .o_digit_valid  (digit_valid),
      .o_blank        (blank),
      .o_invalid      (invalid),
      .o_seq_err      (seq_err),
      .o_change_count (change_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Advance n cycles, sampling on the falling edge and tallying pulses.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (digit_valid === 1'b1) begin
            pulses++;
            pulse_digit = digit;
            chk("pulse_spacing", {31'd0, prev_dv}, 32'd0);
         end
         prev_dv = digit_valid;
      end
   endtask

   // Cycles until the first pulse (0 if none within maxc).
   task automatic wait_pulse(input int maxc, output int lat);
      int p0;
      lat = 0;
      p0 = pulses;
      for (int i = 1; i <= maxc; i++) begin
         run(1);
         if (pulses != p0) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_digit"},  {28'd0, digit}, 32'd0);
      chk({tag, "_dv"},     {31'd0, digit_valid}, 32'd0);
      chk({tag, "_blank"},  {31'd0, blank}, 32'd0);
      chk({tag, "_inv"},    {31'd0, invalid}, 32'd0);
      chk({tag, "_seqerr"}, {31'd0, seq_err}, 32'd0);
      chk({tag, "_count"},  {24'd0, change_count}, 32'd0);
   endtask

   initial begin
      int lat;
      int p0;
      seg_tab[0] = 7'b0111111; seg_tab[1] = 7'b0000110; seg_tab[2] = 7'b1011011;
      seg_tab[3] = 7'b1001111; seg_tab[4] = 7'b1100110; seg_tab[5] = 7'b1101101;
      seg_tab[6] = 7'b1111101; seg_tab[7] = 7'b0000111; seg_tab[8] = 7'b1111111;
      seg_tab[9] = 7'b1101111;

      // 1. reset, blank acceptance, first digit latency
      rst_n = 1'b0; ena = 1'b1; seg_in = 7'd0; clear_err = 1'b0;
      run(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      p0 = pulses;
      run(25);
      chk("blank_set", {31'd0, blank}, 32'd1);
      chk("blank_nopulse", pulses - p0, 32'd0);
      seg_in = seg_tab[0];
      wait_pulse(40, lat);
      chk("lat_digit0", lat, 32'd19);
      chk("digit0", {28'd0, digit}, 32'd0);
      chk("count1", {24'd0, change_count}, 32'd1);
      chk("blank_clr", {31'd0, blank}, 32'd0);
      run(1);
      chk("dv_one_cycle", {31'd0, digit_valid}, 32'd0);
      run(20);

      // 2. count 1..7 then wrap to 0
      p0 = pulses;
      for (int d = 1; d <= 8; d++) begin
         seg_in = seg_tab[d % 8];
         run(40);
         chk("seq_digit", {28'd0, pulse_digit}, d % 8);
      end
      chk("seq_pulses", pulses - p0, 32'd8);
      chk("seq_err_ok", {31'd0, seq_err}, 32'd0);
      chk("count9", {24'd0, change_count}, 32'd9);

      // 3. glitch rejection, then sequence break
      for (int d = 1; d <= 3; d++) begin
         seg_in = seg_tab[d];
         run(40);
      end
      chk("count12", {24'd0, change_count}, 32'd12);
      p0 = pulses;
      seg_in = seg_tab[5];
      run(10);
      seg_in = seg_tab[3];
      run(40);
      chk("glitch_nopulse", pulses - p0, 32'd0);
      chk("glitch_digit", {28'd0, digit}, 32'd3);
      chk("glitch_count", {24'd0, change_count}, 32'd12);
      seg_in = seg_tab[5];
      run(30);
      chk("skip_digit", {28'd0, digit}, 32'd5);
      chk("skip_err", {31'd0, seq_err}, 32'd1);
      chk("count13", {24'd0, change_count}, 32'd13);

      // 4. 2 then 4, clear_err, same-edge set vs clear
      seg_in = seg_tab[2];
      run(40);
      clear_err = 1'b1; run(1); clear_err = 1'b0; run(1);
      chk("clear_err", {31'd0, seq_err}, 32'd0);
      seg_in = seg_tab[4];
      wait_pulse(40, lat);
      chk("lat_digit4", lat, 32'd19);
      chk("err_2_4", {31'd0, seq_err}, 32'd1);
      run(10);
      clear_err = 1'b1; run(1); clear_err = 1'b0; run(1);
      chk("clear_err2", {31'd0, seq_err}, 32'd0);
      seg_in = seg_tab[6];
      p0 = pulses;
      run(18);
      chk("pre_accept_err", {31'd0, seq_err}, 32'd0);
      clear_err = 1'b1;
      run(1);
      clear_err = 1'b0;
      chk("same_edge_pulse", pulses - p0, 32'd1);
      chk("same_edge_err", {31'd0, seq_err}, 32'd1);
      run(10);
      clear_err = 1'b1; run(1); clear_err = 1'b0; run(1);
      chk("clear_err3", {31'd0, seq_err}, 32'd0);

      // 5. invalid pattern then resync on 1
      p0 = pulses;
      seg_in = 7'b1010101;
      run(40);
      chk("invalid_set", {31'd0, invalid}, 32'd1);
      chk("invalid_nopulse", pulses - p0, 32'd0);
      chk("invalid_digit", {28'd0, digit}, 32'd6);
      seg_in = seg_tab[1];
      run(40);
      chk("resync_pulse", pulses - p0, 32'd1);
      chk("resync_invalid", {31'd0, invalid}, 32'd0);
      chk("resync_err", {31'd0, seq_err}, 32'd0);
      chk("count17", {24'd0, change_count}, 32'd17);

      // 6. enable gating, then reset mid-count
      ena = 1'b0;
      p0 = pulses;
      seg_in = seg_tab[9];
      run(50);
      chk("ena0_nopulse", pulses - p0, 32'd0);
      chk("ena0_digit", {28'd0, digit}, 32'd1);
      ena = 1'b1;
      wait_pulse(40, lat);
      chk("ena_lat", lat, 32'd17);
      chk("ena_digit", {28'd0, digit}, 32'd9);
      chk("ena_err", {31'd0, seq_err}, 32'd1);
      chk("count18", {24'd0, change_count}, 32'd18);
      run(10);
      seg_in = seg_tab[2];
      run(13);
      rst_n = 1'b0;
      run(1);
      chk_all_zero("midrst");
      rst_n = 1'b1;
      p0 = pulses;
      wait_pulse(40, lat);
      chk("post_rst_lat", lat, 32'd19);
      chk("post_rst_digit", {28'd0, digit}, 32'd2);
      chk("post_rst_count", {24'd0, change_count}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
